// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel frame sequencer.
package sobel_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, DRAIN} sobel_ctrl_state_t;

  localparam int SOBEL_TAPS = 9;

  // Linear address of padded coordinate (r,c); the padded image is width+2 wide.
  function automatic logic [31:0] sobel_pad_addr(input logic [15:0] r,
                                                 input logic [15:0] c,
                                                 input logic [15:0] width);
    return 32'(r) * (32'(width) + 32'd2) + 32'(c);
  endfunction

endpackage

// File: rtl/sobel_win_reg.sv
// 3x3 tap register: one tap written per load, whole window shifts one column left on shift.
// Tap index m*3+n is packed at taps[(m*3+n)*PIX_W +: PIX_W].
module sobel_win_reg
  import sobel_pkg::*;
#(
  parameter int PIX_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift,
  input  logic                        load,
  input  logic [3:0]                  load_idx,
  input  logic [PIX_W-1:0]            load_dat,
  output logic [SOBEL_TAPS*PIX_W-1:0] taps
);

  logic [PIX_W-1:0] tap_q [SOBEL_TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SOBEL_TAPS; i++) tap_q[i] <= '0;
    end else begin
      if (shift) begin
        for (int m = 0; m < 3; m++) begin
          tap_q[m*3]   <= tap_q[m*3+1];
          tap_q[m*3+1] <= tap_q[m*3+2];
        end
      end
      for (int i = 0; i < SOBEL_TAPS; i++) begin
        if (load && load_idx == 4'(i)) tap_q[i] <= load_dat;
      end
    end
  end

  always_comb begin
    taps = '0;
    for (int i = 0; i < SOBEL_TAPS; i++) taps[i*PIX_W +: PIX_W] = tap_q[i];
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Raster-scans a zero-padded image, fetching each 3x3 window from single-port RAM and issuing it over valid/ready.
// Optional SOBEL_CTRL_WINDOW_REUSE_EN: for col>0 shift the window and fetch only the new column.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int HEIGHT = 5,
  parameter int PIX_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [PIX_W-1:0]      mem_rd_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*PIX_W-1:0]    win_data,
  output logic [15:0]           win_row,
  output logic [15:0]           win_col,
  input  logic                  res_valid
);

  localparam logic [15:0] TOTAL = 16'(HEIGHT * WIDTH);

`ifdef SOBEL_CTRL_WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  sobel_ctrl_state_t state_q, state_d;

  logic [15:0] row_q, col_q, col_nxt, res_cnt_q;
  logic [1:0]  fm_q, fn_q;
  logic        cap_vld_q;
  logic [3:0]  cap_idx_q;
  logic        hs, last_pix, fetch_last, frame_go, shift_nxt;
  logic [1:0]  fn_start, fn_start_nxt;

  assign last_pix   = (row_q == 16'(HEIGHT-1)) && (col_q == 16'(WIDTH-1));
  assign fetch_last = (fm_q == 2'd2) && (fn_q == 2'd2);
  assign frame_go   = (state_q == IDLE) && start && !abort;
  assign hs         = win_valid && win_ready;
  assign col_nxt    = (col_q == 16'(WIDTH-1)) ? 16'd0 : col_q + 16'd1;

  // A partial fetch walks rows of column n=2 only; the other columns come from the shift.
  assign shift_nxt    = REUSE && (col_nxt != 16'd0) && !last_pix;
  assign fn_start     = (REUSE && col_q != 16'd0) ? 2'd2 : 2'd0;
  assign fn_start_nxt = shift_nxt ? 2'd2 : 2'd0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    mem_rd_en = 1'b0;
    win_valid = 1'b0;
    case (state_q)
      IDLE:  if (start && !abort) state_d = FETCH;
      FETCH: begin
        mem_rd_en = 1'b1;
        if (fetch_last) state_d = WAIT;
      end
      WAIT:  state_d = ISSUE;
      ISSUE: begin
        win_valid = 1'b1;
        if (win_ready) state_d = last_pix ? DRAIN : FETCH;
      end
      DRAIN: if (res_cnt_q == TOTAL) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      mem_rd_en = 1'b0;
      win_valid = 1'b0;
      done      = 1'b0;
    end
  end

  assign mem_rd_addr = mem_rd_en
    ? ADDR_W'(sobel_pad_addr(row_q + 16'(fm_q), col_q + 16'(fn_q), 16'(WIDTH)))
    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      res_cnt_q <= '0;
      fm_q      <= '0;
      fn_q      <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      // Read data lands one cycle after the strobe; remember which tap it belongs to.
      cap_vld_q <= mem_rd_en;
      cap_idx_q <= 4'(fm_q) * 4'd3 + 4'(fn_q);
      if (frame_go) begin
        row_q     <= '0;
        col_q     <= '0;
        fm_q      <= '0;
        fn_q      <= '0;
        res_cnt_q <= '0;
      end else begin
        if (res_valid && state_q != IDLE && res_cnt_q != TOTAL)
          res_cnt_q <= res_cnt_q + 16'd1;
        if (mem_rd_en) begin
          if (fn_q == 2'd2) begin
            fn_q <= fn_start;
            fm_q <= fm_q + 2'd1;
          end else begin
            fn_q <= fn_q + 2'd1;
          end
        end
        if (hs && !last_pix) begin
          col_q <= col_nxt;
          if (col_q == 16'(WIDTH-1)) row_q <= row_q + 16'd1;
          fm_q  <= '0;
          fn_q  <= fn_start_nxt;
        end
      end
    end
  end

  sobel_win_reg #(.PIX_W(PIX_W)) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift    (hs && shift_nxt),
    .load     (cap_vld_q),
    .load_idx (cap_idx_q),
    .load_dat (mem_rd_data),
    .taps     (win_data)
  );

  assign win_row = row_q;
  assign win_col = col_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 5x5 frame with RAM[a]=a.
module tb_sobel_frame_ctrl;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 32;
  localparam int AW = 16;
`ifdef SOBEL_CTRL_WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef struct packed {
    logic [15:0]     r;
    logic [15:0]     c;
    logic [9*PW-1:0] d;
  } win_t;

  logic            clk = 1'b0;
  logic            rst, start, abort, busy, done, mem_rd_en;
  logic            win_valid, win_ready, res_valid;
  logic [AW-1:0]   mem_rd_addr;
  logic [PW-1:0]   mem_rd_data;
  logic [9*PW-1:0] win_data;
  logic [15:0]     win_row, win_col;

  int vectors = 0;
  int miscompares = 0;

  win_t        win_q[$];
  logic [15:0] addr_q[$];
  int          res_due[$];

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .res_valid(res_valid)
  );

  // RAM whose content equals its address, 1-cycle read latency.
  always @(posedge clk) mem_rd_data <= PW'(mem_rd_addr);

  task automatic check(input string tag, input logic [9*PW-1:0] got, input logic [9*PW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pad(input int r, input int c);
    return r * (W + 2) + c;
  endfunction

  function automatic int period(input int c);
    return (REUSE && c != 0) ? 5 : 11;
  endfunction

  function automatic win_t exp_win(input int r, input int c);
    win_t e;
    e.r = 16'(r);
    e.c = 16'(c);
    e.d = '0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        e.d[(m*3+n)*PW +: PW] = PW'(pad(r + m, c + n));
    return e;
  endfunction

  task automatic chk_reset(input string p);
    check({p, "_busy"},  busy, 0);
    check({p, "_done"},  done, 0);
    check({p, "_rd_en"}, mem_rd_en, 0);
    check({p, "_addr"},  mem_rd_addr, 0);
    check({p, "_valid"}, win_valid, 0);
    check({p, "_data"},  win_data, 0);
    check({p, "_row"},   win_row, 0);
    check({p, "_col"},   win_col, 0);
  endtask

  // One frame: results return lag cycles after each handshake; win_ready held low
  // bp_len cycles on window (bp_r,bp_c); optional abort at cycle abort_at or rst on the stall.
  task automatic run_frame(input int lag, input int bp_r, input int bp_c, input int bp_len,
                           input int abort_at, input bit rst_on_bp);
    win_t e;
    int   cyc, last_hs, hs_cnt, bp_left, quiet, exp_done;
    bit   prev_valid, fin;
    win_q.delete();
    addr_q.delete();
    res_due.delete();
    exp_done = lag + 1 + ((bp_r >= 0) ? bp_len : 0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        win_q.push_back(exp_win(r, c));
        exp_done += period(c);
        if (REUSE && c > 0) begin
          for (int m = 0; m < 3; m++) addr_q.push_back(16'(pad(r + m, c + 2)));
        end else begin
          for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++) addr_q.push_back(16'(pad(r + m, c + n)));
        end
      end
    end
    @(negedge clk);
    start = 1'b1;
    win_ready = 1'b1;
    res_valid = 1'b0;
    check("busy_pre", busy, 0);
    cyc = 0; last_hs = 0; hs_cnt = 0; bp_left = bp_len; prev_valid = 1'b0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      win_ready = 1'b1;
      if (cyc == 1) check("busy_rise", busy, 1);
      if (abort_at > 0 && cyc == abort_at) begin
        abort = 1'b1;
        res_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", win_valid, 0);
        check("abort_rd_en", mem_rd_en, 0);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done || busy || mem_rd_en) quiet++;
        end
        check("abort_quiet", quiet, 0);
        return;
      end
      if (mem_rd_en) begin
        check("rd_count", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) check("rd_addr", mem_rd_addr, addr_q.pop_front());
      end
      if (win_valid) begin
        check("win_pending", win_q.size() > 0, 1);
        e = (win_q.size() > 0) ? win_q[0] : '0;
        if (!prev_valid) begin
          if (hs_cnt == 0) check("first_valid_cyc", cyc, 11);
          else             check("issue_gap", cyc - last_hs, period(int'(e.c)));
        end
        check("win_row", win_row, e.r);
        check("win_col", win_col, e.c);
        check("win_data", win_data, e.d);
        if (int'(e.r) == bp_r && int'(e.c) == bp_c && bp_left > 0) begin
          win_ready = 1'b0;
          bp_left--;
          if (rst_on_bp) begin
            rst = 1'b1;
            res_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk_reset("rst_issue");
            return;
          end
        end else begin
          void'(win_q.pop_front());
          hs_cnt++;
          last_hs = cyc;
          res_due.push_back(cyc + lag);
        end
      end
      prev_valid = win_valid;
      res_valid = 1'b0;
      if (res_due.size() > 0 && res_due[0] == cyc) begin
        void'(res_due.pop_front());
        res_valid = 1'b1;
      end
      if (done) begin
        check("done_hs", hs_cnt, H * W);
        check("done_cyc", cyc, exp_done);
        @(negedge clk);
        res_valid = 1'b0;
        check("busy_fall", busy, 0);
        check("done_pulse", done, 0);
        fin = 1'b1;
      end
    end
    check("frame_end", fin, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0; res_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");

    run_frame(0, -1, -1, 0, 0, 1'b0);
    run_frame(20, -1, -1, 0, 0, 1'b0);
    run_frame(0, 2, 3, 7, 0, 1'b0);
    run_frame(0, -1, -1, 0, 50, 1'b0);
    run_frame(20, -1, -1, 0, 0, 1'b0);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_rd_en", mem_rd_en, 0);
    @(negedge clk);
    check("sa_busy2", busy, 0);

    run_frame(0, 1, 2, 5, 0, 1'b1);
    run_frame(3, -1, -1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
